// File: rtl/rv32i_pkg.sv
// RV32I decode definitions shared by the decode stage and its helpers.
// Opcodes, ALU operation and immediate-type encodings, control bundle.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic alu_src_imm;
        logic alu_src_pc;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jal;
        logic jalr;
    } ctrl_t;

    // alt selects SUB/SRA; callers pass 0 where funct7[5] is immediate data
    function automatic alu_op_e alu_from_f3(
        input logic [2:0] f3,
        input logic       alt
    );
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction and sign extension for the RV32I formats.
// Purely combinational; IMM_NONE yields zero.
module imm_gen
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  imm_type_e       imm_type_i,
    output logic [XLEN-1:0] imm_o
);

    logic        s;
    logic [31:0] imm32;

    assign s = instr_i[31];

    always_comb begin
        imm32 = 32'd0;
        unique case (imm_type_i)
            IMM_I: imm32 = {{20{s}}, instr_i[31:20]};
            IMM_S: imm32 = {{20{s}}, instr_i[31:25],
                            instr_i[11:7]};
            IMM_B: imm32 = {{19{s}}, s, instr_i[7],
                            instr_i[30:25],
                            instr_i[11:8], 1'b0};
            IMM_U: imm32 = {instr_i[31:12], 12'd0};
            IMM_J: imm32 = {{11{s}}, s, instr_i[19:12],
                            instr_i[20], instr_i[30:21],
                            1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_unit.sv
// RV32I decode stage: combinational decoder feeding one
// valid/payload register with a valid/ready handshake.
module decode_unit
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic             flush_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [XLEN-1:0]  pc_o,
    output logic [RF_AW-1:0] rs1_o,
    output logic [RF_AW-1:0] rs2_o,
    output logic [RF_AW-1:0] rd_o,
    output logic [XLEN-1:0]  imm_o,
    output logic [3:0]       alu_op_o,
    output logic [2:0]       funct3_o,
    output logic             alu_src_imm_o,
    output logic             alu_src_pc_o,
    output logic             reg_write_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             branch_o,
    output logic             jal_o,
    output logic             jalr_o,
    output logic             illegal_o
);

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [RF_AW-1:0] rs1;
        logic [RF_AW-1:0] rs2;
        logic [RF_AW-1:0] rd;
        logic [XLEN-1:0]  imm;
        alu_op_e          alu_op;
        logic [2:0]       funct3;
        ctrl_t            ctrl;
        logic             illegal;
    } payload_t;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    imm_type_e       imm_type;
    alu_op_e         alu_op;
    ctrl_t           ctrl;
    logic            illegal;
    logic [XLEN-1:0] imm;

    payload_t dec;
    payload_t pay_d, pay_q;
    logic     valid_d, valid_q;
    logic     accept;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];

    always_comb begin
        imm_type = IMM_NONE;
        alu_op   = ALU_ADD;
        ctrl     = '0;
        illegal  = 1'b0;
        unique case (opcode)
            OPC_LUI: begin
                imm_type         = IMM_U;
                alu_op           = ALU_PASSB;
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write   = 1'b1;
            end
            OPC_AUIPC: begin
                imm_type         = IMM_U;
                ctrl.alu_src_imm = 1'b1;
                ctrl.alu_src_pc  = 1'b1;
                ctrl.reg_write   = 1'b1;
            end
            OPC_JAL: begin
                imm_type         = IMM_J;
                ctrl.alu_src_imm = 1'b1;
                ctrl.alu_src_pc  = 1'b1;
                ctrl.reg_write   = 1'b1;
                ctrl.jal         = 1'b1;
            end
            OPC_JALR: begin
                imm_type         = IMM_I;
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write   = 1'b1;
                ctrl.jalr        = 1'b1;
                illegal          = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                imm_type    = IMM_B;
                alu_op      = ALU_SUB;
                ctrl.branch = 1'b1;
                illegal     = (f3 == 3'b010) ||
                              (f3 == 3'b011);
            end
            OPC_LOAD: begin
                imm_type         = IMM_I;
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_read    = 1'b1;
                ctrl.reg_write   = 1'b1;
                illegal          = (f3 == 3'b011) ||
                                   (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                imm_type         = IMM_S;
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_write   = 1'b1;
                illegal          = (f3 >= 3'b011);
            end
            OPC_OP_IMM: begin
                imm_type         = IMM_I;
                alu_op           = alu_from_f3(
                    f3, (f3 == 3'b101) && f7[5]);
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write   = 1'b1;
                // only the shifts carry a funct7 field
                illegal = ((f3 == 3'b001) &&
                           (f7 != F7_BASE)) ||
                          ((f3 == 3'b101) &&
                           (f7 != F7_BASE) &&
                           (f7 != F7_ALT));
            end
            OPC_OP: begin
                alu_op         = alu_from_f3(f3, f7[5]);
                ctrl.reg_write = 1'b1;
                illegal = ((f7 != F7_BASE) &&
                           (f7 != F7_ALT)) ||
                          ((f7 == F7_ALT) &&
                           (f3 != 3'b000) &&
                           (f3 != 3'b101));
            end
            OPC_FENCE: begin
                imm_type = IMM_NONE;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        if (illegal) begin
            ctrl   = '0;
            alu_op = ALU_ADD;
        end
        if (instr_i[11:7] == 5'd0) begin
            ctrl.reg_write = 1'b0;
        end
    end

    imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .instr_i   (instr_i),
        .imm_type_i(imm_type),
        .imm_o     (imm)
    );

    always_comb begin
        dec         = '0;
        dec.pc      = pc_i;
        dec.rs1     = RF_AW'(instr_i[19:15]);
        dec.rs2     = RF_AW'(instr_i[24:20]);
        dec.rd      = RF_AW'(instr_i[11:7]);
        dec.imm     = imm;
        dec.alu_op  = alu_op;
        dec.funct3  = f3;
        dec.ctrl    = ctrl;
        dec.illegal = illegal;
    end

    assign instr_ready_o = !valid_q || ready_i;
    assign accept        = instr_valid_i && instr_ready_o;

    // flush wins over acceptance and leaves the payload untouched
    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            pay_d   = dec;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
        end
    end

    assign valid_o       = valid_q;
    assign pc_o          = pay_q.pc;
    assign rs1_o         = pay_q.rs1;
    assign rs2_o         = pay_q.rs2;
    assign rd_o          = pay_q.rd;
    assign imm_o         = pay_q.imm;
    assign alu_op_o      = pay_q.alu_op;
    assign funct3_o      = pay_q.funct3;
    assign alu_src_imm_o = pay_q.ctrl.alu_src_imm;
    assign alu_src_pc_o  = pay_q.ctrl.alu_src_pc;
    assign reg_write_o   = pay_q.ctrl.reg_write;
    assign mem_read_o    = pay_q.ctrl.mem_read;
    assign mem_write_o   = pay_q.ctrl.mem_write;
    assign branch_o      = pay_q.ctrl.branch;
    assign jal_o         = pay_q.ctrl.jal;
    assign jalr_o        = pay_q.ctrl.jalr;
    assign illegal_o     = pay_q.illegal;

endmodule

// File: tb/tb_decode_unit.sv
// Scoreboard bench for decode_unit: directed instructions with
// hand-computed bundles, checked by a separate output monitor.
module tb_decode_unit;

    logic        clock;
    logic        reset_n;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic        flush_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [31:0] imm_o;
    logic [3:0]  alu_op_o;
    logic [2:0]  funct3_o;
    logic        alu_src_imm_o, alu_src_pc_o;
    logic        reg_write_o, mem_read_o, mem_write_o;
    logic        branch_o, jal_o, jalr_o, illegal_o;

    typedef struct {
        string       name;
        logic [95:0] v;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    decode_unit #(
        .XLEN (32),
        .RF_AW(5)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .instr_i      (instr_i),
        .pc_i         (pc_i),
        .instr_valid_i(instr_valid_i),
        .instr_ready_o(instr_ready_o),
        .flush_i      (flush_i),
        .ready_i      (ready_i),
        .valid_o      (valid_o),
        .pc_o         (pc_o),
        .rs1_o        (rs1_o),
        .rs2_o        (rs2_o),
        .rd_o         (rd_o),
        .imm_o        (imm_o),
        .alu_op_o     (alu_op_o),
        .funct3_o     (funct3_o),
        .alu_src_imm_o(alu_src_imm_o),
        .alu_src_pc_o (alu_src_pc_o),
        .reg_write_o  (reg_write_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .branch_o     (branch_o),
        .jal_o        (jal_o),
        .jalr_o       (jalr_o),
        .illegal_o    (illegal_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // flags: {src_imm,src_pc,rw,mrd,mwr,br,jal,jalr,ill}
    function automatic logic [95:0] pk(
        input logic [31:0] pc,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [4:0]  rd,
        input logic [31:0] imm,
        input logic [3:0]  alu,
        input logic [2:0]  f3,
        input logic [8:0]  fl
    );
        return {1'b0, pc, rs1, rs2, rd, imm, alu, f3, fl};
    endfunction

    function automatic logic [95:0] dut_bundle();
        return pk(pc_o, rs1_o, rs2_o, rd_o, imm_o,
                  alu_op_o, funct3_o,
                  {alu_src_imm_o, alu_src_pc_o,
                   reg_write_o, mem_read_o,
                   mem_write_o, branch_o, jal_o,
                   jalr_o, illegal_o});
    endfunction

    task automatic chk(
        input string       nm,
        input logic [95:0] act,
        input logic [95:0] exp
    );
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h",
                     nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && valid_o) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_bundle actual=%h required=none",
                         dut_bundle());
            end else begin
                chk(q[0].name, dut_bundle(), q[0].v);
                if (ready_i) void'(q.pop_front());
            end
        end
    end

    task automatic issue(
        input string       nm,
        input logic [31:0] ins,
        input logic [31:0] pc,
        input logic [95:0] exp,
        input logic        fl
    );
        int n;
        n             = 0;
        instr_i       = ins;
        pc_i          = pc;
        instr_valid_i = 1'b1;
        flush_i       = fl;
        while (!instr_ready_o && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!instr_ready_o) begin
            tests++;
            fails++;
            $display("FAIL %s_accept actual=timeout required=ready",
                     nm);
        end else if (!fl) begin
            q.push_back('{nm, exp});
        end
        @(posedge clock);
        #1;
        instr_valid_i = 1'b0;
        flush_i       = 1'b0;
        chk({nm, "_valid"}, 96'(valid_o), 96'(!fl));
    endtask

    initial begin
        reset_n       = 1'b0;
        instr_i       = 32'd0;
        pc_i          = 32'd0;
        instr_valid_i = 1'b0;
        flush_i       = 1'b0;
        ready_i       = 1'b1;
        #12;
        chk("reset_bundle", dut_bundle(), 96'd0);
        chk("reset_valid", 96'(valid_o), 96'd0);
        chk("reset_ready", 96'(instr_ready_o), 96'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        issue("addi", 32'h00500093, 32'h0,
              pk(32'h0, 0, 5, 1, 32'h5, 0, 0,
                 9'b101000000), 1'b0);
        issue("beq", 32'hFE000EE3, 32'h100,
              pk(32'h100, 0, 0, 29, 32'hFFFFFFFC, 1, 0,
                 9'b000001000), 1'b0);
        @(posedge clock);
        #1;
        chk("drop_valid", 96'(valid_o), 96'd0);

        ready_i = 1'b0;
        issue("add_x3", 32'h002081B3, 32'h10,
              pk(32'h10, 1, 2, 3, 32'h0, 0, 0,
                 9'b001000000), 1'b0);
        instr_i       = 32'h407302B3;
        pc_i          = 32'h14;
        instr_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_ready", 96'(instr_ready_o), 96'd0);
            @(posedge clock);
            #1;
        end
        ready_i = 1'b1;
        q.push_back('{"sub_x5",
            pk(32'h14, 6, 7, 5, 32'h0, 1, 0,
               9'b001000000)});
        @(posedge clock);
        #1;
        instr_valid_i = 1'b0;
        chk("bp_valid", 96'(valid_o), 96'd1);
        chk("bp_pc", 96'(pc_o), 96'h14);
        @(posedge clock);
        #1;

        issue("lui_flushed", 32'h123453B7, 32'h20,
              96'd0, 1'b1);
        issue("auipc", 32'h00001417, 32'h200,
              pk(32'h200, 0, 0, 8, 32'h1000, 0, 1,
                 9'b111000000), 1'b0);
        issue("lui", 32'h123453B7, 32'h24,
              pk(32'h24, 8, 3, 7, 32'h12345000, 10, 5,
                 9'b101000000), 1'b0);
        issue("all_ones", 32'hFFFFFFFF, 32'h300,
              pk(32'h300, 31, 31, 31, 32'h0, 0, 7,
                 9'b000000001), 1'b0);
        issue("add_x0", 32'h00208033, 32'h304,
              pk(32'h304, 1, 2, 0, 32'h0, 0, 0,
                 9'b000000000), 1'b0);
        issue("sw", 32'h0020A423, 32'h308,
              pk(32'h308, 1, 2, 8, 32'h8, 0, 2,
                 9'b100010000), 1'b0);
        issue("srai", 32'h40325213, 32'h30C,
              pk(32'h30C, 4, 3, 4, 32'h403, 7, 5,
                 9'b101000000), 1'b0);
        issue("jal", 32'h008000EF, 32'h310,
              pk(32'h310, 0, 8, 1, 32'h8, 0, 0,
                 9'b111000100), 1'b0);
        issue("lw", 32'hFFF12283, 32'h314,
              pk(32'h314, 2, 31, 5, 32'hFFFFFFFF, 0, 2,
                 9'b101100000), 1'b0);
        issue("xor_f7_ill", 32'h4020C1B3, 32'h318,
              pk(32'h318, 1, 2, 3, 32'h0, 0, 4,
                 9'b000000001), 1'b0);
        issue("fence", 32'h0FF0000F, 32'h31C,
              pk(32'h31C, 0, 31, 0, 32'h0, 0, 0,
                 9'b000000000), 1'b0);
        @(posedge clock);
        #1;

        ready_i = 1'b0;
        issue("addi_held", 32'h00500093, 32'h400,
              pk(32'h400, 0, 5, 1, 32'h5, 0, 0,
                 9'b101000000), 1'b0);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        q.delete();
        chk("rst_mid_valid", 96'(valid_o), 96'd0);
        chk("rst_mid_bundle", dut_bundle(), 96'd0);
        chk("rst_mid_ready", 96'(instr_ready_o), 96'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            chk("post_rst_idle", 96'(valid_o), 96'd0);
        end
        issue("addi_after", 32'h00500093, 32'h404,
              pk(32'h404, 0, 5, 1, 32'h5, 0, 0,
                 9'b101000000), 1'b0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        chk("sb_empty", 96'(q.size()), 96'd0);

        $display("[TB] %0d tests run, %0d failed",
                 tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=done");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/decode_unit.md
DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 The block SHALL have these parameters: XLEN, default 32, datapath width; RF_AW, default 5, register index width.
REQ-002 The block SHALL have these ports:
- clock  in  1  single rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- instr_i  in  32  instruction word from the fetch unit's instruction output
- pc_i  in  32  PC of instr_i, from the fetch unit's address output
- instr_valid_i  in  1  instr_i/pc_i valid this cycle
- instr_ready_o  out  1  decode can accept this cycle
- flush_i  in  1  discard held and incoming instruction (branch redirect)
- ready_i  in  1  downstream execute stage accepts
- valid_o  out  1  decoded bundle valid
- pc_o  out  32  PC of decoded instruction
- rs1_o, rs2_o, rd_o  out  5  register indices
- imm_o  out  32  sign-extended immediate
- alu_op_o  out  4  alu_op_e encoding
- funct3_o  out  3  raw funct3, for branch and load/store sizing
- alu_src_imm_o, alu_src_pc_o  out  1  ALU operand-B immediate / operand-A PC select
- reg_write_o, mem_read_o, mem_write_o, branch_o, jal_o, jalr_o  out  1  control flags
- illegal_o  out  1  unsupported encoding

Function
REQ-003 Accepting an instruction SHALL require instr_valid_i && instr_ready_o at a rising edge.
REQ-004 instr_ready_o SHALL equal !valid_o || ready_i, combinationally.
REQ-005 An accepted instruction SHALL appear on all outputs exactly 1 cycle later.
REQ-006 All outputs SHALL be registered.
REQ-007 While valid_o=1 and ready_i=0, all outputs SHALL hold unchanged.
REQ-008 When ready_i=1 and no new instruction is accepted, valid_o SHALL drop to 0 on the next edge.
REQ-009 A new instruction accepted while the downstream also consumes the held one SHALL replace the held bundle (back-to-back, no bubble).
REQ-010 flush_i SHALL clear valid_o on the next edge, overriding a simultaneous acceptance.
REQ-011 The payload register SHALL hold its value while flush_i is asserted.
REQ-012 Supported opcodes SHALL be LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP and FENCE.
REQ-013 FENCE SHALL decode as a NOP with all control flags 0.
REQ-014 Immediates SHALL be generated per type as I, S, B, U and J; B and J SHALL have bit 0 forced to 0; U SHALL be {instr[31:12],12'b0}.
REQ-015 R-type instructions SHALL set imm_o to 0.
REQ-016 alu_op_o SHALL decode to:
- ADD for ADD, ADDI, loads, stores, AUIPC, JAL, JALR
- SUB for SUB and branches
- PASSB for LUI
- otherwise from funct3 and funct7[5]: SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
REQ-017 Illegal encodings SHALL be: unknown opcode; OP with funct7 not in {0x00,0x20}; funct7=0x20 on anything except SUB/SRA; SLLI/SRLI/SRAI with a bad funct7; branch funct3 of 010 or 011; load funct3 of 011, 110 or 111; store funct3 >= 011; JALR funct3 != 0.
REQ-018 An illegal instruction SHALL set illegal_o=1 and force all control flags to 0; valid_o SHALL still assert.
REQ-019 reg_write_o SHALL be forced to 0 when rd=0.
REQ-020 STORE and BRANCH SHALL set reg_write_o=0.

Reset
REQ-021 While reset_n=0, all outputs SHALL be 0, asynchronously, and the block SHALL report instr_ready_o=1.
REQ-022 Reset mid-operation SHALL discard any held instruction.
REQ-023 The first acceptance SHALL occur no earlier than the first edge after reset_n rises.

Structure
REQ-024 A shared package rv32i_pkg SHALL hold the opcode localparams, the alu_op_e enum (4-bit) and the imm_type_e enum (I/S/B/U/J/NONE).
REQ-025 Immediate generation SHALL live in one combinational sub-module, imm_gen (instr, imm_type -> imm).
REQ-026 The decode logic SHALL be combinational in front of a single valid/payload register stage.

Verification
REQ-027 The bench SHALL cover at least these directed scenarios:
- ADDI x1,x0,5 (0x00500093) accepted -> next cycle valid_o=1, rd_o=1, rs1_o=0, imm_o=5, alu_op_o=ADD, alu_src_imm_o=1, reg_write_o=1.
- BEQ x0,x0,-4 (0xFE000EE3) at pc_i=0x100 -> imm_o=0xFFFFFFFC, branch_o=1, alu_op_o=SUB, reg_write_o=0, pc_o=0x100.
- Backpressure: hold ready_i=0 for 3 cycles with a second instruction waiting -> instr_ready_o=0 and outputs stable; raise ready_i -> second instruction appears exactly 1 cycle later.
- flush_i and a valid instruction in the same cycle -> valid_o=0 next cycle; the following instruction decodes normally.
- 0xFFFFFFFF, then ADD x0,x1,x2 (0x00208033) -> first gives illegal_o=1 with all flags 0; second gives reg_write_o=0 (rd=0).
- reset_n pulsed low mid-stream with valid_o=1 -> valid_o=0 immediately; no stale bundle reappears after release.
